// File: rtl/shift_ex_stage_if.sv
// rtl/shift_ex_stage_if.sv - upstream/downstream handshake bundle for the shift execute stage
interface shift_ex_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [5:0]            in_funct;
    logic [4:0]            in_shamt;
    logic [DATA_WIDTH-1:0] in_rs;
    logic [DATA_WIDTH-1:0] in_rt;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_illegal;

    modport master (
        output in_valid, in_funct, in_shamt, in_rs, in_rt, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_funct, in_shamt, in_rs, in_rt, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_illegal
    );
endinterface

// File: rtl/shift_ex_stage.sv
// rtl/shift_ex_stage.sv - MIPS shift decode + barrel shift with a 2-entry elastic output buffer
module shift_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    shift_ex_stage_if.slave   bus
);
    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_ZERO = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_SRL  = 2'b11;

    logic [1:0]            shiftop;
    logic [4:0]            shift_b;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] shift_res;

    always_comb begin
        shiftop = OP_ZERO;
        shift_b = bus.in_shamt;
        illegal = 1'b0;
        case (bus.in_funct)
            6'b000000: shiftop = OP_SLL;
            6'b000010: shiftop = OP_SRL;
            6'b000011: shiftop = OP_SRA;
            6'b000100: begin shiftop = OP_SLL; shift_b = bus.in_rs[4:0]; end
            6'b000110: begin shiftop = OP_SRL; shift_b = bus.in_rs[4:0]; end
            6'b000111: begin shiftop = OP_SRA; shift_b = bus.in_rs[4:0]; end
            default:   illegal = 1'b1;
        endcase
    end

    // Barrel shifter: A = rt, B = amount, Shiftop selects the operation (01 yields zero).
    always_comb begin
        shift_res = '0;
        case (shiftop)
            OP_SLL:  shift_res = bus.in_rt << shift_b;
            OP_SRL:  shift_res = bus.in_rt >> shift_b;
            OP_SRA:  shift_res = $signed(bus.in_rt) >>> shift_b;
            default: shift_res = '0;
        endcase
    end

    logic                  e0_valid_q, e0_valid_d;
    logic [DATA_WIDTH-1:0] e0_result_q, e0_result_d;
    logic [REG_ADDR_W-1:0] e0_rd_q, e0_rd_d;
    logic                  e0_illegal_q, e0_illegal_d;
    logic                  e1_valid_q, e1_valid_d;
    logic [DATA_WIDTH-1:0] e1_result_q, e1_result_d;
    logic [REG_ADDR_W-1:0] e1_rd_q, e1_rd_d;
    logic                  e1_illegal_q, e1_illegal_d;
    logic                  in_ready_q, in_ready_d;

    logic push;
    logic pop;

    assign push = bus.in_valid & in_ready_q;
    assign pop  = e0_valid_q & bus.out_ready;

    always_comb begin
        e0_valid_d   = e0_valid_q;
        e0_result_d  = e0_result_q;
        e0_rd_d      = e0_rd_q;
        e0_illegal_d = e0_illegal_q;
        e1_valid_d   = e1_valid_q;
        e1_result_d  = e1_result_q;
        e1_rd_d      = e1_rd_q;
        e1_illegal_d = e1_illegal_q;

        if (pop) begin
            if (e1_valid_q) begin
                // Skid entry drains into the output register; push is blocked here.
                e0_result_d  = e1_result_q;
                e0_rd_d      = e1_rd_q;
                e0_illegal_d = e1_illegal_q;
                e1_valid_d   = 1'b0;
            end else if (push) begin
                e0_result_d  = shift_res;
                e0_rd_d      = bus.in_rd;
                e0_illegal_d = illegal;
            end else begin
                e0_valid_d   = 1'b0;
            end
        end else if (push) begin
            if (!e0_valid_q) begin
                e0_valid_d   = 1'b1;
                e0_result_d  = shift_res;
                e0_rd_d      = bus.in_rd;
                e0_illegal_d = illegal;
            end else begin
                e1_valid_d   = 1'b1;
                e1_result_d  = shift_res;
                e1_rd_d      = bus.in_rd;
                e1_illegal_d = illegal;
            end
        end

        in_ready_d = ~e1_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            e0_valid_q   <= 1'b0;
            e0_result_q  <= '0;
            e0_rd_q      <= '0;
            e0_illegal_q <= 1'b0;
            e1_valid_q   <= 1'b0;
            e1_result_q  <= '0;
            e1_rd_q      <= '0;
            e1_illegal_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            e0_valid_q   <= e0_valid_d;
            e0_result_q  <= e0_result_d;
            e0_rd_q      <= e0_rd_d;
            e0_illegal_q <= e0_illegal_d;
            e1_valid_q   <= e1_valid_d;
            e1_result_q  <= e1_result_d;
            e1_rd_q      <= e1_rd_d;
            e1_illegal_q <= e1_illegal_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = e0_valid_q;
    assign bus.out_result  = e0_result_q;
    assign bus.out_rd      = e0_rd_q;
    assign bus.out_illegal = e0_illegal_q;
endmodule

// File: tb/tb_shift_ex_stage.sv
// tb/tb_shift_ex_stage.sv - directed-vector bench for shift_ex_stage
module tb_shift_ex_stage;
    logic clk;
    logic resetn;
    int   n_vec;
    int   n_bad;

    shift_ex_stage_if #(.DATA_WIDTH(32), .REG_ADDR_W(5)) sif ();

    shift_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] funct, input logic [4:0] shamt,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
        sif.in_valid = 1'b1;
        sif.in_funct = funct;
        sif.in_shamt = shamt;
        sif.in_rs    = rs;
        sif.in_rt    = rt;
        sif.in_rd    = rd;
    endtask

    // Apply one word for one edge, return at the following falling edge with in_valid low.
    task automatic issue(input logic [5:0] funct, input logic [4:0] shamt,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
        drive(funct, shamt, rs, rt, rd);
        @(posedge clk);
        @(negedge clk);
        sif.in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [31:0] res,
                             input logic [4:0] rd, input logic ill);
        chk({tag, ".valid"},   {31'd0, sif.out_valid}, 32'd1);
        chk({tag, ".result"},  sif.out_result, res);
        chk({tag, ".rd"},      {27'd0, sif.out_rd}, {27'd0, rd});
        chk({tag, ".illegal"}, {31'd0, sif.out_illegal}, {31'd0, ill});
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        resetn = 1'b0;
        sif.out_ready = 1'b1;
        drive(6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
        sif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.valid",   {31'd0, sif.out_valid}, 32'd0);
        chk("rst.ready",   {31'd0, sif.in_ready}, 32'd1);
        chk("rst.result",  sif.out_result, 32'd0);
        chk("rst.rd",      {27'd0, sif.out_rd}, 32'd0);
        chk("rst.illegal", {31'd0, sif.out_illegal}, 32'd0);
        resetn = 1'b1;

        issue(6'b000000, 5'd4, 32'h0, 32'h000000F1, 5'd7);
        check_out("sll4", 32'h00000F10, 5'd7, 1'b0);
        issue(6'b000111, 5'd0, 32'hFFFFFFFF, 32'h80000000, 5'd3);
        check_out("srav31", 32'hFFFFFFFF, 5'd3, 1'b0);
        issue(6'b000110, 5'd0, 32'hFFFFFFFF, 32'h80000000, 5'd4);
        check_out("srlv31", 32'h00000001, 5'd4, 1'b0);
        issue(6'b000111, 5'd0, 32'h00000025, 32'h80000000, 5'd5);
        check_out("srav5", 32'hFC000000, 5'd5, 1'b0);
        issue(6'b000011, 5'd0, 32'h0, 32'h80001234, 5'd6);
        check_out("sra0", 32'h80001234, 5'd6, 1'b0);
        issue(6'b000010, 5'd8, 32'h0, 32'hA5000000, 5'd8);
        check_out("srl8", 32'h00A50000, 5'd8, 1'b0);
        issue(6'b000100, 5'd0, 32'hFFFFFFE3, 32'h00000003, 5'd9);
        check_out("sllv3", 32'h00000018, 5'd9, 1'b0);
        issue(6'b100000, 5'd4, 32'h0, 32'h12345678, 5'd10);
        check_out("illegal", 32'h00000000, 5'd10, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("idle.valid", {31'd0, sif.out_valid}, 32'd0);

        // Back-pressure: two words fill the buffer, third must stall.
        sif.out_ready = 1'b0;
        issue(6'b000000, 5'd1, 32'h0, 32'h1, 5'd1);
        chk("stall.ready1", {31'd0, sif.in_ready}, 32'd1);
        issue(6'b000000, 5'd2, 32'h0, 32'h1, 5'd2);
        chk("stall.ready2", {31'd0, sif.in_ready}, 32'd0);
        drive(6'b000000, 5'd3, 32'h0, 32'h1, 5'd3);
        @(posedge clk);
        @(negedge clk);
        chk("stall.ready3", {31'd0, sif.in_ready}, 32'd0);
        check_out("stall.hold", 32'h2, 5'd1, 1'b0);
        sif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_out("drain1", 32'h4, 5'd2, 1'b0);
        chk("drain1.ready", {31'd0, sif.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        sif.in_valid = 1'b0;
        check_out("drain2", 32'h8, 5'd3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("drain.empty", {31'd0, sif.out_valid}, 32'd0);

        // Full-rate streaming.
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                check_out($sformatf("stream%0d", i - 1), (32'h3 + 32'h11 * (i - 1)) << (i - 1),
                          5'(i - 1), 1'b0);
                chk($sformatf("stream%0d.ready", i - 1), {31'd0, sif.in_ready}, 32'd1);
            end
            if (i < 16) drive(6'b000000, 5'(i), 32'h0, 32'h3 + 32'h11 * i, 5'(i));
            else sif.in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        chk("stream.empty", {31'd0, sif.out_valid}, 32'd0);

        // Reset with both entries full and a word offered.
        sif.out_ready = 1'b0;
        issue(6'b000000, 5'd5, 32'h0, 32'h1, 5'd11);
        issue(6'b000000, 5'd6, 32'h0, 32'h1, 5'd12);
        chk("full.ready", {31'd0, sif.in_ready}, 32'd0);
        drive(6'b000000, 5'd7, 32'h0, 32'h1, 5'd13);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst2.valid",   {31'd0, sif.out_valid}, 32'd0);
        chk("rst2.ready",   {31'd0, sif.in_ready}, 32'd1);
        chk("rst2.result",  sif.out_result, 32'd0);
        chk("rst2.rd",      {27'd0, sif.out_rd}, 32'd0);
        chk("rst2.illegal", {31'd0, sif.out_illegal}, 32'd0);
        resetn = 1'b1;
        sif.in_valid = 1'b0;
        sif.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst2.no_emit", {31'd0, sif.out_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
